// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divider controller for DIV/DIVU.
// Define DIV_ZERO_FAST_EN to retire divide-by-zero through a one-cycle ZERO state.
`timescale 1ns/1ps
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  output logic        stall,
  output logic        valid,
  output logic [63:0] result
);

`ifdef DIV_ZERO_FAST_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ZERO} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [63:0] res_q, res_d;

  logic        accept;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, diff;
  logic        ge;
  logic [31:0] step_rem, step_quo;
  logic [31:0] q_mag, r_mag;
  logic [31:0] q_fix, r_fix;

  assign accept = start & ~flush &
                  ((state_q == IDLE) | (state_q == DONE));

  assign a_neg = signed_div & opa[31];
  assign b_neg = signed_div & opb[31];
  assign a_mag = a_neg ? -opa : opa;
  assign b_mag = b_neg ? -opb : opb;

  // shift remainder:quotient left one bit, then trial-subtract
  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign ge       = ~diff[32];
  assign step_rem = ge ? diff[31:0] : shifted[31:0];
  assign step_quo = {quo_q[30:0], ge};

  always_comb begin
    q_mag = step_quo;
    r_mag = step_rem;
`ifdef DIV_ZERO_FAST_EN
    // ZERO keeps the dividend magnitude in quo_q
    if (state_q == ZERO) begin
      q_mag = 32'hFFFF_FFFF;
      r_mag = quo_q;
    end
`endif
  end

  assign q_fix = negq_q ? -q_mag : q_mag;
  assign r_fix = negr_q ? -r_mag : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          cnt_d   = 5'd31;
          state_d = BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (opb == '0) state_d = ZERO;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == '0) begin
            state_d = DONE;
            res_d   = {r_fix, q_fix};
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
`ifdef DIV_ZERO_FAST_EN
      ZERO: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          res_d   = {r_fix, q_fix};
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
    end
  end

`ifdef DIV_ZERO_FAST_EN
  assign stall = (state_q == BUSY) | (state_q == ZERO) | accept;
`else
  assign stall = (state_q == BUSY) | accept;
`endif
  assign valid  = (state_q == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl with an arithmetic reference.
// Directed spec vectors, flush/reset cases, then randomized back-to-back traffic.
`timescale 1ns/1ps
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        stall;
  logic        valid;
  logic [63:0] result;

  div_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .signed_div(signed_div), .opa(opa), .opb(opb),
    .flush(flush), .stall(stall), .valid(valid),
    .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] exp;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          last_due = 0;
  logic [63:0] last_res = '0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic s);
    logic [31:0] q, r;
    longint sa, sb_, lq, lr;
    if (b == 32'd0) begin
      r = a;
      q = (s && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      lq  = sa / sb_;
      lr  = sa % sb_;
      q   = lq[31:0];
      r   = lr[31:0];
    end
    return {r, q};
  endfunction

  function automatic int lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 32'd0) ? 2 : 33;
`else
    return 33;
`endif
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp);
    opa        = a;
    opb        = b;
    signed_div = s;
    start      = 1'b1;
    flush      = 1'b0;
    last_due   = cyc + lat(b);
    sb.push_back('{exp, last_due});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit noise);
    while (cyc < last_due) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      opa   = $urandom;
      opb   = $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    logic es;
    if (mon_en && !rst) begin
      es = (start && !flush) ||
           (sb.size() > 0 && cyc < sb[0].due);
      chk("stall", 64'(stall), 64'(es));
      if (valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid got 1 want 0 (cycle %0d)", cyc);
        end else begin
          chk("latency", 64'(cyc), 64'(sb[0].due));
          chk("result", result, sb[0].exp);
          last_res = sb[0].exp;
          void'(sb.pop_front());
        end
      end else begin
        chk("hold", result, last_res);
        if (sb.size() > 0 && cyc >= sb[0].due) begin
          checks++;
          errors++;
          $display("FAIL missing_valid got 0 want 1 (cycle %0d)", cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t dir[6] = '{
    '{32'd100,        32'd7,          1'b0, {32'h2,         32'hE}},
    '{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}},
    '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0,         32'h8000_0000}},
    '{32'hFFFF_FFF9,  32'd0,          1'b1, {32'hFFFF_FFF9, 32'h1}},
    '{32'd0,          32'd0,          1'b0, {32'h0,         32'hFFFF_FFFF}},
    '{32'hFFFF_FFFF,  32'd1,          1'b0, {32'h0,         32'hFFFF_FFFF}}
  };

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          mode, k;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    signed_div = 1'b0; opa = '0; opb = '0;
    #1;
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_result", result, 64'd0);
    idle(2);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // directed vectors, chained back-to-back through the DONE cycle
    for (int i = 0; i < 6; i++) begin
      issue(dir[i].a, dir[i].b, dir[i].s, dir[i].exp);
      wait_done(1'b0);
    end
    idle(3);

    // flush at cycle 10 together with a start that must be dropped
    issue(32'd100, 32'd7, 1'b0, {32'h2, 32'hE});
    idle(9);
    opa = 32'd5; opb = 32'd1; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    start = 1'b0; flush = 1'b0;
    idle(40);

    // reset at cycle 15 of an operation
    issue(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333});
    idle(14);
    rst = 1'b1;
    #1;
    sb.delete();
    last_res = '0;
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_result", result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(40);

    // randomized traffic with busy-time start noise and occasional flushes
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 7);
      a = (mode == 3) ? 32'($urandom_range(0, 300)) : $urandom;
      b = (mode == 0) ? 32'd0 :
          (mode == 1) ? 32'($urandom_range(1, 15)) :
          (mode == 2) ? 32'hFFFF_FFFF : $urandom;
      s = 1'($urandom_range(0, 1));
      issue(a, b, s, model(a, b, s));
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(1, lat(b) - 1);
        idle(k - 1);
        flush = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        flush = 1'b0;
      end else begin
        wait_done(1'b1);
        if ($urandom_range(0, 1) == 1)
          idle($urandom_range(1, 3));
      end
    end

    start = 1'b0;
    idle(40);
    chk("drain", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
